// File: rtl/filt_fir_int.sv
// Purpose     : interpolate-by-L polyphase FIR, one shared MAC time-multiplexed over P taps x L phases.
// Latency     : phase p output registered P*(p+1) enabled edges after the accept edge; block busy for N edges.
// Backpressure: o_ready high only in IDLE; i_valid while busy is ignored (no buffering, upstream holds/drops).
//
// Ports:
//   i_clk, i_rst_an   clock (rising edge) and asynchronous active-low reset
//   i_ena             clock enable, every register holds while low
//   i_valid, i_data   input sample strobe and signed sample
//   o_ready           idle, able to accept a sample
//   o_valid, o_data   one-cycle strobe and signed output sample (held between strobes)
module filt_fir_int #(
    parameter int gp_data_width   = 8,
    parameter int gp_coeff_width  = 8,
    parameter int gp_interp       = 4,
    parameter int gp_coeff_length = 16,
    parameter logic [gp_coeff_length*gp_coeff_width-1:0] gp_coeff =
        128'h100F0E0D0C0B0A090807060504030201,
    parameter int gp_oup_width    = gp_data_width + gp_coeff_width + gp_coeff_length / gp_interp
) (
    input  logic                           i_clk,
    input  logic                           i_rst_an,
    input  logic                           i_ena,
    input  logic                           i_valid,
    input  logic signed [gp_data_width-1:0] i_data,
    output logic                           o_ready,
    output logic                           o_valid,
    output logic signed [gp_oup_width-1:0] o_data
);

    localparam int lp_taps  = gp_coeff_length / gp_interp;
    localparam int lp_jw    = (lp_taps > 1) ? $clog2(lp_taps) : 1;
    localparam int lp_pw    = $clog2(gp_interp);
    localparam int lp_pw_ok = (lp_pw > 0) ? lp_pw : 1;
    localparam int lp_prodw = gp_data_width + gp_coeff_width;

    typedef enum logic {ST_IDLE, ST_MAC} state_t;

    state_t state, state_nxt;

    logic signed [gp_data_width-1:0]  dly [lp_taps];
    logic signed [gp_oup_width-1:0]   acc;
    logic [lp_jw-1:0]                 tap_cnt;
    logic [lp_pw_ok-1:0]              phase_cnt;

    // Coefficients regrouped as coeff[j][p] = h[j*L+p] so the MAC indexes by tap and phase directly.
    logic signed [gp_coeff_width-1:0] coeff [lp_taps][gp_interp];

    for (genvar j = 0; j < lp_taps; j++) begin : g_tap
        for (genvar p = 0; p < gp_interp; p++) begin : g_phase
            assign coeff[j][p] = gp_coeff[(j*gp_interp+p+1)*gp_coeff_width-1 -: gp_coeff_width];
        end
    end

    logic                           last_tap;
    logic                           last_phase;
    logic                           accept;
    logic signed [lp_prodw-1:0]     prod;
    logic signed [gp_oup_width-1:0] mac_sum;

    assign last_tap   = (tap_cnt == lp_jw'(lp_taps - 1));
    assign last_phase = (phase_cnt == lp_pw_ok'(gp_interp - 1));
    assign accept     = (state == ST_IDLE) && i_valid;

    // Full-precision signed product, sign-extended (or wrapped) into the accumulator width.
    assign prod    = dly[tap_cnt] * coeff[tap_cnt][phase_cnt];
    assign mac_sum = acc + gp_oup_width'(prod);

    // State register
    always_ff @(posedge i_clk or negedge i_rst_an) begin
        if (!i_rst_an) begin
            state <= ST_IDLE;
        end else if (i_ena) begin
            state <= state_nxt;
        end
    end

    // Next-state logic
    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE: if (i_valid)                state_nxt = ST_MAC;
            ST_MAC:  if (last_tap && last_phase) state_nxt = ST_IDLE;
            default:                             state_nxt = ST_IDLE;
        endcase
    end

    // Output decode from the registered state
    always_comb begin
        o_ready = (state == ST_IDLE);
    end

    // Datapath: delay line, accumulator, counters, output register
    always_ff @(posedge i_clk or negedge i_rst_an) begin
        if (!i_rst_an) begin
            for (int k = 0; k < lp_taps; k++) dly[k] <= '0;
            acc       <= '0;
            tap_cnt   <= '0;
            phase_cnt <= '0;
            o_valid   <= 1'b0;
            o_data    <= '0;
        end else if (i_ena) begin
            o_valid <= 1'b0;
            if (accept) begin
                for (int k = lp_taps - 1; k > 0; k--) dly[k] <= dly[k-1];
                dly[0]    <= i_data;
                acc       <= '0;
                tap_cnt   <= '0;
                phase_cnt <= '0;
            end else if (state == ST_MAC) begin
                if (last_tap) begin
                    // Final tap of a phase goes straight to the output, accumulator restarts for the next phase.
                    o_data    <= mac_sum;
                    o_valid   <= 1'b1;
                    acc       <= '0;
                    tap_cnt   <= '0;
                    phase_cnt <= last_phase ? '0 : phase_cnt + lp_pw_ok'(1);
                end else begin
                    acc     <= mac_sum;
                    tap_cnt <= tap_cnt + lp_jw'(1);
                end
            end
        end
    end

endmodule

// File: tb/tb_filt_fir_int.sv
module tb_filt_fir_int;

    localparam int N  = 16;
    localparam int L  = 4;
    localparam int P  = N / L;
    localparam int DW = 8;
    localparam int OW = 20;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic i_ena = 1'b1;
    logic i_valid = 1'b0;
    logic signed [DW-1:0] din [3];

    logic                 o_ready_w [3];
    logic                 o_valid_w [3];
    logic signed [OW-1:0] o_data_w  [3];

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int last_acc = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // DUT 0: default taps 1..16; DUT 1: all -128; DUT 2: all +1
    filt_fir_int u_dut0 (
        .i_clk(clk), .i_rst_an(rst_n), .i_ena(i_ena), .i_valid(i_valid), .i_data(din[0]),
        .o_ready(o_ready_w[0]), .o_valid(o_valid_w[0]), .o_data(o_data_w[0]));

    filt_fir_int #(.gp_coeff({16{8'h80}})) u_dut1 (
        .i_clk(clk), .i_rst_an(rst_n), .i_ena(i_ena), .i_valid(i_valid), .i_data(din[1]),
        .o_ready(o_ready_w[1]), .o_valid(o_valid_w[1]), .o_data(o_data_w[1]));

    filt_fir_int #(.gp_coeff({16{8'h01}})) u_dut2 (
        .i_clk(clk), .i_rst_an(rst_n), .i_ena(i_ena), .i_valid(i_valid), .i_data(din[2]),
        .o_ready(o_ready_w[2]), .o_valid(o_valid_w[2]), .o_data(o_data_w[2]));

    // ---------------- behavioural model ----------------
    // On accept: history shifts, all L outputs y[p] = sum_j hist[j]*h[j*L+p] are computed at once.
    // Output p then appears P*(p+1) enabled edges later; busy for N enabled edges.
    longint h_m   [3][N];
    longint hist  [3][P];
    longint outs  [3][L];
    bit     m_vld [3];
    longint m_dat [3];
    int     busy_rem;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            busy_rem = 0;
            for (int d = 0; d < 3; d++) begin
                m_vld[d] = 1'b0;
                m_dat[d] = 0;
                for (int j = 0; j < P; j++) hist[d][j] = 0;
            end
        end else if (i_ena) begin
            for (int d = 0; d < 3; d++) m_vld[d] = 1'b0;
            if (busy_rem == 0) begin
                if (i_valid) begin
                    for (int d = 0; d < 3; d++) begin
                        for (int j = P - 1; j > 0; j--) hist[d][j] = hist[d][j-1];
                        hist[d][0] = longint'(din[d]);
                        for (int p = 0; p < L; p++) begin
                            outs[d][p] = 0;
                            for (int j = 0; j < P; j++) outs[d][p] += hist[d][j] * h_m[d][j*L+p];
                        end
                    end
                    busy_rem = N;
                end
            end else begin
                int k;
                k = N - busy_rem + 1;
                busy_rem--;
                if (k % P == 0) begin
                    for (int d = 0; d < 3; d++) begin
                        m_vld[d] = 1'b1;
                        m_dat[d] = outs[d][k/P-1];
                    end
                end
            end
        end
    end

    // ---------------- per-cycle compare + output logs ----------------
    longint lv0 [$];
    longint lv1 [$];
    longint lv2 [$];
    int     lc0 [$];

    always @(negedge clk) begin
        for (int d = 0; d < 3; d++) begin
            checks++;
            if (o_valid_w[d] !== m_vld[d]) begin
                errors++;
                $display("FAIL o_valid dut%0d cyc %0d: got %0b want %0b", d, cyc, o_valid_w[d], m_vld[d]);
            end
            checks++;
            if (o_ready_w[d] !== (busy_rem == 0)) begin
                errors++;
                $display("FAIL o_ready dut%0d cyc %0d: got %0b want %0b", d, cyc, o_ready_w[d], busy_rem == 0);
            end
            checks++;
            if (longint'(o_data_w[d]) != m_dat[d]) begin
                errors++;
                $display("FAIL o_data dut%0d cyc %0d: got %0d want %0d", d, cyc, o_data_w[d], m_dat[d]);
            end
        end
        if (o_valid_w[0] === 1'b1) begin lv0.push_back(longint'(o_data_w[0])); lc0.push_back(cyc); end
        if (o_valid_w[1] === 1'b1) lv1.push_back(longint'(o_data_w[1]));
        if (o_valid_w[2] === 1'b1) lv2.push_back(longint'(o_data_w[2]));
    end

    // ---------------- helpers ----------------
    task automatic chk(input string name, input longint act, input longint exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d want %0d", name, act, exp);
        end
    endtask

    task automatic wait_idle();
        int t = 0;
        while (busy_rem != 0 && t < 200) begin @(negedge clk); t++; end
        checks++;
        if (t >= 200) begin errors++; $display("FAIL idle_timeout: got busy %0d want 0", busy_rem); end
    endtask

    task automatic send(input logic signed [DW-1:0] v);
        wait_idle();
        din[0]  = v;
        i_valid = 1'b1;
        @(negedge clk);
        i_valid  = 1'b0;
        last_acc = cyc;
    endtask

    task automatic clear_logs();
        lv0.delete(); lv1.delete(); lv2.delete(); lc0.delete();
    endtask

    task automatic chk_impulse(input string tag);
        chk({tag, "_count"}, lv0.size(), 2*N);
        for (int k = 0; k < N && k < lv0.size(); k++) chk({tag, "_val"}, lv0[k], k + 1);
    endtask

    // ---------------- stimulus ----------------
    initial begin
        int c;
        for (int k = 0; k < N; k++) begin
            h_m[0][k] = k + 1;
            h_m[1][k] = -128;
            h_m[2][k] = 1;
        end
        din[0] = '0;
        din[1] = -8'sd128;
        din[2] = 8'sd3;

        repeat (3) @(negedge clk);
        for (int d = 0; d < 3; d++) begin
            chk("reset_valid", o_valid_w[d], 0);
            chk("reset_data",  o_data_w[d], 0);
            chk("reset_ready", o_ready_w[d], 1);
        end
        rst_n = 1'b1;
        @(negedge clk);

        // Impulse with timing checks and ignored busy strobes
        clear_logs();
        send(8'sd1);
        c = last_acc;
        repeat (3) @(negedge clk);
        din[0] = 8'sd55; i_valid = 1'b1;
        @(negedge clk);
        i_valid = 1'b0;
        repeat (5) @(negedge clk);
        din[0] = -8'sd90; i_valid = 1'b1;
        @(negedge clk);
        i_valid = 1'b0;
        while (cyc < c + 15) @(negedge clk);
        chk("busy_ready_c15", o_ready_w[0], 0);
        @(negedge clk);
        chk("idle_ready_c16", o_ready_w[0], 1);
        for (int k = 0; k < 4; k++) send(8'sd0);
        wait_idle();
        repeat (2) @(negedge clk);
        for (int p = 0; p < L && p < lc0.size(); p++) chk("impulse_timing", lc0[p] - c, (p + 1) * P);
        chk("impulse_count", lv0.size(), 20);
        for (int k = 0; k < lv0.size(); k++) chk("impulse_val", lv0[k], (k < N) ? k + 1 : 0);

        // Clock enable gap in the middle of phase 1
        clear_logs();
        send(8'sd1);
        c = last_acc;
        while (cyc < c + 5) @(negedge clk);
        i_ena = 1'b0;
        repeat (3) @(negedge clk);
        i_ena = 1'b1;
        wait_idle();
        repeat (2) @(negedge clk);
        chk("ena_count", lv0.size(), L);
        for (int p = 0; p < L && p < lv0.size(); p++) begin
            chk("ena_val", lv0[p], p + 1);
            chk("ena_timing", lc0[p] - c, (p + 1) * P + ((p >= 1) ? 3 : 0));
        end

        // Asynchronous reset during phase 2
        send(8'sd7);
        c = last_acc;
        while (cyc < c + 10) @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        chk("abort_valid", o_valid_w[0], 0);
        chk("abort_data",  o_data_w[0], 0);
        chk("abort_ready", o_ready_w[0], 1);
        @(negedge clk);
        rst_n = 1'b1;
        clear_logs();
        send(8'sd1);
        for (int k = 0; k < 3; k++) send(8'sd0);
        wait_idle();
        repeat (2) @(negedge clk);
        chk("post_reset_count", lv0.size(), N);
        for (int k = 0; k < lv0.size(); k++) chk("post_reset_val", lv0[k], k + 1);
        // Extreme values and DC gain over the same four inputs
        chk("ext_count", lv1.size(), N);
        chk("dc_count",  lv2.size(), N);
        for (int k = 0; k < 4 && lv1.size() == N; k++) begin
            chk("ext_first",  lv1[k], 16384);
            chk("ext_steady", lv1[12+k], 65536);
        end
        for (int k = 0; k < 4 && lv2.size() == N; k++) begin
            chk("dc_first",  lv2[k], 3);
            chk("dc_steady", lv2[12+k], 12);
        end

        // Randomized traffic: random samples, strobes and enable drops
        for (int t = 0; t < 1500; t++) begin
            @(negedge clk);
            i_ena   = ($urandom_range(0, 7) != 0);
            i_valid = ($urandom_range(0, 2) == 0);
            din[0]  = DW'($urandom);
        end
        @(negedge clk);
        i_ena = 1'b1;
        i_valid = 1'b0;
        wait_idle();
        repeat (3) @(negedge clk);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: got running want finished");
        $fatal(1);
    end

endmodule
